// File: rtl/lcd_responder_pkg.sv
// Shared definitions for the HD44780-style LCD responder: opcode prefixes,
// address-counter geometry, the space code and the FSM state encoding.
package lcd_responder_pkg;

  // FSM states: IDLE is the only non-busy state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FILL = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // Instruction opcode prefixes. Each is one-hot on its leading '1' bit, so
  // testing them from the highest bit down gives the decode priority.
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  // Address counter geometry: two 40-position lines.
  localparam logic [6:0] AC_LINE1_BASE  = 7'h00;
  localparam logic [6:0] AC_LINE2_BASE  = 7'h40;
  localparam logic [6:0] AC_LINE1_LIMIT = 7'h27;
  localparam logic [6:0] AC_LINE2_LIMIT = 7'h67;

  localparam logic [7:0] SPACE_CODE = 8'h20;
  localparam int unsigned DDRAM_DEPTH = 32;
  localparam logic [4:0] LAST_INDEX = 5'(DDRAM_DEPTH - 1);

  // True when the instruction carries the given prefix bit.
  function automatic logic has_prefix(input logic [7:0] db, input logic [7:0] op);
    return |(db & op);
  endfunction

  // Next AC value in increment or decrement direction, wrapping between the
  // two line windows.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == AC_LINE1_LIMIT)      nxt = AC_LINE2_BASE;
      else if (ac == AC_LINE2_LIMIT) nxt = AC_LINE1_BASE;
      else                           nxt = ac + 7'd1;
    end else begin
      if (ac == AC_LINE2_BASE)       nxt = AC_LINE1_LIMIT;
      else if (ac == AC_LINE1_BASE)  nxt = AC_LINE2_LIMIT;
      else                           nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  // Returns {mapped, index}: only the first 16 positions of each line are
  // backed by DDRAM entries.
  function automatic logic [5:0] ac_lookup(input logic [6:0] ac);
    logic mapped;
    mapped = (ac[6:4] == AC_LINE1_BASE[6:4]) || (ac[6:4] == AC_LINE2_BASE[6:4]);
    return {mapped, ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display data memory: one write port and two independent registered
// read ports (controller bus side and local RD_ADDR side).
module lcd_ddram (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [4:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [32];

  // Single write port plus two registered reads with one cycle of latency.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/lcd_responder.sv
// Character-LCD controller model: answers an HD44780-style bus, keeps a
// 32-entry DDRAM, an address counter and a busy flag, and exposes the DDRAM
// to local logic through RD_ADDR/RD_DATA.
//
// Bus handshake: the controller owns LCD_E. A transaction is the falling edge
// of the synchronized enable; RS/RW/DB are sampled from the same synchronizer
// stage in that cycle. Writes are accepted only while BUSY=0 (otherwise they
// are dropped and OVERRUN sticks); reads are always answered while E is high.
module lcd_responder
  import lcd_responder_pkg::*;
#(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DB_IN,
  output logic [7:0] LCD_DB_OUT,
  output logic       LCD_DB_OE,
  output logic       BUSY,
  output logic       DISP_ON,
  output logic [6:0] AC,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic       OVERRUN,
  output logic [1:0] fsm_state,
  output logic [5:0] mode
);

  localparam int MAX_COUNT = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  // Synchronizer stages and edge history.
  logic       e_s1, e_s2, e_prev;
  logic       rs_s1, rs_s2;
  logic       rw_s1, rw_s2;
  logic [7:0] db_s1, db_s2;

  logic       fall, wr_strobe, rd_strobe, bus_read;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0] fill_idx;

  logic       cmd_rs;
  logic [7:0] cmd_db;
  logic       cmd_is_clear;

  logic [6:0] ac_q;
  logic       id_q, disp_q, dl_q, n_q, f_q, c_q, b_q;
  logic       overrun_q;

  logic [5:0] ac_map;
  logic       ac_mapped;
  logic [4:0] ac_index;
  logic       map_q;

  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [7:0] bus_rdata;

  assign fall         = e_prev & ~e_s2;
  assign wr_strobe    = fall & ~rw_s2;
  assign rd_strobe    = fall & rw_s2;
  assign bus_read     = e_s2 & rw_s2;
  assign cmd_is_clear = ~cmd_rs && (cmd_db == OP_CLEAR);

  assign ac_map    = ac_lookup(ac_q);
  assign ac_mapped = ac_map[5];
  assign ac_index  = ac_map[4:0];

  // Two-flop synchronizer for all bus inputs, plus one extra E stage for
  // falling-edge detection.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      e_s1   <= 1'b0;
      e_s2   <= 1'b0;
      e_prev <= 1'b0;
      rs_s1  <= 1'b0;
      rs_s2  <= 1'b0;
      rw_s1  <= 1'b0;
      rw_s2  <= 1'b0;
      db_s1  <= 8'h00;
      db_s2  <= 8'h00;
    end else begin
      e_s1   <= LCD_E;
      e_s2   <= e_s1;
      e_prev <= e_s2;
      rs_s1  <= LCD_RS;
      rs_s2  <= rs_s1;
      rw_s1  <= LCD_RW;
      rw_s2  <= rw_s1;
      db_s1  <= LCD_DB_IN;
      db_s2  <= db_s1;
    end
  end

  // FSM state register; reset lands in FILL so the display starts cleared.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wr_strobe) state_d = ST_EXEC;
      ST_EXEC: state_d = cmd_is_clear ? ST_FILL : ST_WAIT;
      ST_FILL: if (fill_idx == LAST_INDEX) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill index and busy countdown. FILL keeps reloading the clear delay so
  // WAIT starts with it after the last entry.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      fill_idx <= 5'd0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          fill_idx <= 5'd0;
          cnt_q    <= BUSY_LOAD;
        end
        ST_FILL: begin
          fill_idx <= fill_idx + 5'd1;
          cnt_q    <= CLEAR_LOAD;
        end
        ST_WAIT: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Latch an accepted write; flag writes that arrive while busy.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cmd_rs    <= 1'b0;
      cmd_db    <= 8'h00;
      overrun_q <= 1'b0;
    end else if (wr_strobe) begin
      if (state_q == ST_IDLE) begin
        cmd_rs <= rs_s2;
        cmd_db <= db_s2;
      end else begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Instruction execution, clear completion and data-read AC stepping.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ac_q   <= AC_LINE1_BASE;
      id_q   <= 1'b1;
      disp_q <= 1'b0;
      c_q    <= 1'b0;
      b_q    <= 1'b0;
      dl_q   <= 1'b1;
      n_q    <= 1'b1;
      f_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      if (cmd_rs) begin
        ac_q <= ac_step(ac_q, id_q);
      end else if (has_prefix(cmd_db, OP_SET_DDRAM)) begin
        ac_q <= cmd_db[6:0];
      end else if (has_prefix(cmd_db, OP_SET_CGRAM)) begin
        ac_q <= ac_q;
      end else if (has_prefix(cmd_db, OP_FUNC_SET)) begin
        dl_q <= cmd_db[4];
        n_q  <= cmd_db[3];
        f_q  <= cmd_db[2];
      end else if (has_prefix(cmd_db, OP_SHIFT)) begin
        if (!cmd_db[3]) ac_q <= ac_step(ac_q, cmd_db[2]);
      end else if (has_prefix(cmd_db, OP_DISP_CTRL)) begin
        disp_q <= cmd_db[2];
        c_q    <= cmd_db[1];
        b_q    <= cmd_db[0];
      end else if (has_prefix(cmd_db, OP_ENTRY)) begin
        id_q <= cmd_db[1];
      end else if (has_prefix(cmd_db, OP_HOME)) begin
        ac_q <= AC_LINE1_BASE;
      end
    end else if ((state_q == ST_FILL) && (fill_idx == LAST_INDEX)) begin
      ac_q <= AC_LINE1_BASE;
      id_q <= 1'b1;
    end else if (rd_strobe && rs_s2) begin
      ac_q <= ac_step(ac_q, id_q);
    end
  end

  // DDRAM write source: space fill during FILL, data write during EXEC.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ac_index;
    ram_wdata = cmd_db;
    if (state_q == ST_FILL) begin
      ram_we    = 1'b1;
      ram_waddr = fill_idx;
      ram_wdata = SPACE_CODE;
    end else if ((state_q == ST_EXEC) && cmd_rs && ac_mapped) begin
      ram_we = 1'b1;
    end
  end

  lcd_ddram u_ddram (
    .clk     (CLK),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (ac_index),
    .rdata_a (bus_rdata),
    .raddr_b (RD_ADDR),
    .rdata_b (RD_DATA)
  );

  // Bus read return: status or DDRAM[AC], driven while synchronized E is high.
  // map_q tracks the cycle the bus read port was addressed.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      map_q      <= 1'b0;
      LCD_DB_OE  <= 1'b0;
      LCD_DB_OUT <= 8'h00;
    end else begin
      map_q     <= ac_mapped;
      LCD_DB_OE <= bus_read;
      if (!bus_read)   LCD_DB_OUT <= 8'h00;
      else if (rs_s2)  LCD_DB_OUT <= map_q ? bus_rdata : SPACE_CODE;
      else             LCD_DB_OUT <= {BUSY, ac_q};
    end
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign DISP_ON   = disp_q;
  assign AC        = ac_q;
  assign OVERRUN   = overrun_q;
  assign fsm_state = state_q;
  assign mode      = {dl_q, n_q, f_q, c_q, b_q, id_q};

endmodule
